// File: rtl/braille_dot_driver_pkg.sv
// Shared definitions for the Braille dot driver: code constants, FSM states
// and the ASCII-to-dot lookup used at FIFO write time.
package braille_dot_driver_pkg;

  localparam logic [7:0] ASCII_A  = 8'h61;
  localparam logic [7:0] ASCII_Z  = 8'h7A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Returns {ok, pattern}; pattern bit k drives Braille dot k+1.
  function automatic logic [6:0] braille_pat(input logic [7:0] ascii);
    logic [6:0] res;
    case (ascii)
      ASCII_SP: res = {1'b1, 6'b000000};
      8'h61:    res = {1'b1, 6'b000001};
      8'h62:    res = {1'b1, 6'b000011};
      8'h63:    res = {1'b1, 6'b001001};
      8'h64:    res = {1'b1, 6'b011001};
      8'h65:    res = {1'b1, 6'b010001};
      8'h66:    res = {1'b1, 6'b001011};
      8'h67:    res = {1'b1, 6'b011011};
      8'h68:    res = {1'b1, 6'b010011};
      8'h69:    res = {1'b1, 6'b001010};
      8'h6A:    res = {1'b1, 6'b011010};
      8'h6B:    res = {1'b1, 6'b000101};
      8'h6C:    res = {1'b1, 6'b000111};
      8'h6D:    res = {1'b1, 6'b001101};
      8'h6E:    res = {1'b1, 6'b011101};
      8'h6F:    res = {1'b1, 6'b010101};
      8'h70:    res = {1'b1, 6'b001111};
      8'h71:    res = {1'b1, 6'b011111};
      8'h72:    res = {1'b1, 6'b010111};
      8'h73:    res = {1'b1, 6'b001110};
      8'h74:    res = {1'b1, 6'b011110};
      8'h75:    res = {1'b1, 6'b100101};
      8'h76:    res = {1'b1, 6'b100111};
      8'h77:    res = {1'b1, 6'b111010};
      8'h78:    res = {1'b1, 6'b101101};
      8'h79:    res = {1'b1, 6'b111101};
      8'h7A:    res = {1'b1, 6'b110101};
      default:  res = {1'b0, 6'b000000};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/braille_dot_driver_fifo.sv
// Small synchronous FIFO holding translated 6-bit dot patterns.
// full/empty are registered alongside the count so they never glitch.
module braille_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [5:0]               wdata,
  output logic [5:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;
  logic [5:0]    mem_q [DEPTH];

  // Next-state for pointers, occupancy and flags; requests are gated by the registered flags.
  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = pop & ~empty_q;
    wr_ptr_d = do_push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = do_pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == CW'(0));
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/braille_dot_driver.sv
// Braille actuator driver: translates incoming characters into dot patterns,
// buffers them, and shows each for HOLD_CYCLES followed by a GAP_CYCLES blank.
module braille_dot_driver
  import braille_dot_driver_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 10_000_000,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_BW      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [7:0] i_alpha,
  output logic [5:0] o_dots,
  output logic       o_busy,
  output logic       o_full,
  output logic       o_drop,
  output logic       o_err,
  output logic       o_char_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_BW-1:0] HOLD_LD = CNT_BW'(HOLD_CYCLES - 1);
  localparam logic [CNT_BW-1:0] GAP_LD  = CNT_BW'(GAP_CYCLES - 1);

  logic [6:0]        lut;
  logic              code_ok;
  logic              push, pop;
  logic [5:0]        fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count, count_nxt;

  state_e            state_q, state_d;
  logic [CNT_BW-1:0] timer_q, timer_d;
  logic [5:0]        dots_q, dots_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  braille_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (lut[5:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Write path: translate on arrival, reject unsupported codes, flag overflow.
  always_comb begin
    lut     = braille_pat(i_alpha);
    code_ok = lut[6];
    push    = i_valid & code_ok & ~fifo_full;
    err_d   = i_valid & ~code_ok;
    drop_d  = i_valid & code_ok & fifo_full;
  end

  // Display FSM and hold/gap timer; GAP expiry chains straight into the next SHOW.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dots_d  = dots_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          dots_d  = fifo_rdata;
          timer_d = HOLD_LD;
          state_d = ST_SHOW;
        end else begin
          dots_d  = 6'b000000;
          state_d = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (timer_q == {CNT_BW{1'b0}}) begin
          dots_d  = 6'b000000;
          timer_d = GAP_LD;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q - CNT_BW'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == {CNT_BW{1'b0}}) begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            dots_d  = fifo_rdata;
            timer_d = HOLD_LD;
            state_d = ST_SHOW;
          end else begin
            dots_d  = 6'b000000;
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - CNT_BW'(1);
        end
      end
      default: begin
        dots_d  = 6'b000000;
        timer_d = {CNT_BW{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
    count_nxt = fifo_count + CW'(push) - CW'(pop);
    busy_d    = (state_d != ST_IDLE) || (count_nxt != CW'(0));
  end

  // FSM, timer and output registers; dots fall to zero the moment reset asserts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= {CNT_BW{1'b0}};
      dots_q  <= 6'b000000;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dots_q  <= dots_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign o_dots      = dots_q;
  assign o_busy      = busy_q;
  assign o_full      = fifo_full;
  assign o_drop      = drop_q;
  assign o_err       = err_q;
  assign o_char_done = done_q;

endmodule

// File: tb/tb_braille_dot_driver.sv
// Scoreboard bench for braille_dot_driver: a timeline model predicts pop edges,
// dots, busy/full per cycle and the err/drop/char_done pulses.
module tb_braille_dot_driver;

  localparam int H  = 8;
  localparam int G  = 3;
  localparam int D  = 4;
  localparam int HN = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_alpha = 8'h00;
  logic [5:0] o_dots;
  logic       o_busy, o_full, o_drop, o_err, o_char_done;

  always #5 clk = ~clk;

  braille_dot_driver #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .FIFO_DEPTH  (D),
    .CNT_BW      (32)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .i_valid     (i_valid),
    .i_alpha     (i_alpha),
    .o_dots      (o_dots),
    .o_busy      (o_busy),
    .o_full      (o_full),
    .o_drop      (o_drop),
    .o_err       (o_err),
    .o_char_done (o_char_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Accepted characters: push edge, pop edge, pattern.
  int         rec_t[$];
  int         rec_p[$];
  logic [5:0] rec_pat[$];

  typedef struct { int done_edge; logic [5:0] pat; } exp_t;
  typedef struct { int kind; int edge_n; } ev_t;  // kind 0 = err, 1 = drop
  exp_t exp_q[$];
  ev_t  ev_q[$];

  logic [5:0] hist [HN];

  string dots_tbl [26] = '{"1", "12", "14", "145", "15", "124", "1245", "125", "24", "245",
                           "13", "123", "134", "1345", "135", "1234", "12345", "1235", "234",
                           "2345", "136", "1236", "2456", "1346", "13456", "1356"};

  function automatic logic [6:0] ref_pat(input logic [7:0] c);
    logic [5:0] p = 6'b000000;
    string s;
    if (c == 8'h20) return {1'b1, 6'b000000};
    if (c < 8'h61 || c > 8'h7A) return 7'b0000000;
    s = dots_tbl[int'(c) - 97];
    for (int i = 0; i < s.len(); i++) p[int'(s[i]) - 49] = 1'b1;
    return {1'b1, p};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", name, act, exp_v, cyc);
  endtask

  task automatic model_accept(input logic [7:0] c, input int t);
    logic [6:0] rp;
    int occ;
    int p;
    ev_t ev;
    exp_t ex;
    rp  = ref_pat(c);
    occ = 0;
    if (!rp[6]) begin
      ev.kind = 0; ev.edge_n = t; ev_q.push_back(ev);
      return;
    end
    foreach (rec_t[k]) if (rec_t[k] < t && rec_p[k] >= t) occ++;
    if (occ >= D) begin
      ev.kind = 1; ev.edge_n = t; ev_q.push_back(ev);
      return;
    end
    p = t + 1;
    if (rec_p.size() > 0 && rec_p[rec_p.size()-1] + H + G > p) p = rec_p[rec_p.size()-1] + H + G;
    rec_t.push_back(t);
    rec_p.push_back(p);
    rec_pat.push_back(rp[5:0]);
    ex.done_edge = p + H + G;
    ex.pat = rp[5:0];
    exp_q.push_back(ex);
  endtask

  task automatic model_clear();
    rec_t.delete();
    rec_p.delete();
    rec_pat.delete();
    exp_q.delete();
    ev_q.delete();
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    i_valid = 1'b1;
    i_alpha = c;
    model_accept(c, cyc + 1);
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_alpha = 8'h00;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    quiet(1);
    while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size() + ev_q.size()), 32'd0);
    quiet(2);
  endtask

  // Monitor: per-cycle model comparison plus scoreboard pops on pulses.
  initial begin
    int e;
    logic [5:0] ed;
    logic eb;
    int occ;
    exp_t ex;
    ev_t ev;
    forever begin
      @(negedge clk);
      e = cyc;
      hist[e % HN] = o_dots;
      if (!rst) begin
        ed = 6'b000000; eb = 1'b0; occ = 0;
        foreach (rec_t[k]) begin
          if (rec_p[k] <= e && e < rec_p[k] + H) ed = rec_pat[k];
          if (rec_t[k] <= e && e < rec_p[k] + H + G) eb = 1'b1;
          if (rec_t[k] <= e && rec_p[k] > e) occ++;
        end
        chk("dots", 32'(o_dots), 32'(ed));
        chk("busy", 32'(o_busy), 32'(eb));
        chk("full", 32'(o_full), 32'(occ == D));
        if (o_char_done) begin
          if (exp_q.size() == 0) chk("done_unexpected", 32'(o_char_done), 32'd0);
          else begin
            ex = exp_q.pop_front();
            chk("done_edge", 32'(e), 32'(ex.done_edge));
            chk("char_pattern", 32'(hist[(e - H - G) % HN]), 32'(ex.pat));
          end
        end
        if (o_err || o_drop) begin
          if (ev_q.size() == 0) chk("pulse_unexpected", 32'({o_drop, o_err}), 32'd0);
          else begin
            ev = ev_q.pop_front();
            chk("pulse_kind", 32'({o_drop, o_err}), (ev.kind == 1) ? 32'd2 : 32'd1);
            chk("pulse_edge", 32'(e), 32'(ev.edge_n));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] c;
    int r;
    // Reset state
    #20;
    chk("rst_dots", 32'(o_dots), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_pulses", 32'({o_err, o_drop, o_char_done}), 32'd0);
    #2 rst = 1'b0;
    quiet(3);

    // Single 'b'
    send(8'h62);
    quiet(20);
    chk("b_idle_busy", 32'(o_busy), 32'd0);

    // Burst a, b, c
    send(8'h61); send(8'h62); send(8'h63);
    drain("burst_abc_drain");

    // Six back-to-back: one dropped
    send(8'h64); send(8'h68); send(8'h6A); send(8'h6B); send(8'h6D); send(8'h6E);
    drain("overflow_drain");

    // Unsupported codes, then 'z'
    send(8'h41); send(8'hFF);
    quiet(5);
    chk("err_busy_low", 32'(o_busy), 32'd0);
    send(8'h7A);
    drain("z_drain");

    // Space between 'a' and 'c'
    send(8'h61); send(8'h20); send(8'h63);
    drain("space_drain");

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       c = 8'h61 + 8'($urandom_range(0, 25));
      else if (r == 7) c = 8'h20;
      else             c = 8'($urandom_range(0, 255));
      send(c);
      r = $urandom_range(0, 14);
      if (r > 0) quiet(r);
    end
    drain("random_drain");

    // Reset mid-SHOW with two queued
    send(8'h6D); send(8'h6E); send(8'h6F);
    quiet(4);
    @(posedge clk);
    #1;
    chk("pre_rst_dots", 32'(o_dots), 32'(6'b001101));
    #1 rst = 1'b1;
    #1;
    chk("async_rst_dots", 32'(o_dots), 32'd0);
    model_clear();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    quiet(30);
    chk("post_rst_busy", 32'(o_busy), 32'd0);
    chk("post_rst_dots", 32'(o_dots), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
